cacheline_mem_adapter: RTL and testbench

- Initiator side of the cache-line memory interface. Accepts one line-wide read or write request from the cache (upstream port).
- Runs it as one burst transaction on the physical-memory port (mem_read/mem_write, mem_address, mem_rdata, mem_wdata, mem_byte_enable, mem_resp, pm_error) against the burst memory responder.
- On reads, assembles BURST_LEN beats into a line. On writes, slices the line into beats. Watches for responder errors and timeouts.

---
 rtl/cacheline_mem_adapter.sv | 194 +++++++++++++++++++
 tb/tb_cacheline_mem_adapter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_mem_adapter.sv
// cacheline_mem_adapter: runs one cache-line read or write as a single burst on the
// physical-memory port, assembling read beats into a line or slicing a line into write beats.
// Traps conflicting requests, responder errors and response timeouts into a sticky ERROR state.
module cacheline_mem_adapter #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int BURST_LEN        = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst,
  // upstream cache side
  input  logic                                      line_read,
  input  logic                                      line_write,
  input  logic [ADDR_WIDTH-1:0]                     line_address,
  input  logic [CACHE_LINE_WIDTH-1:0]               line_wdata,
  output logic [CACHE_LINE_WIDTH-1:0]               line_rdata,
  output logic                                      line_resp,
  output logic                                      busy,
  output logic                                      err,
  // physical-memory burst side
  output logic                                      mem_read,
  output logic                                      mem_write,
  output logic [ADDR_WIDTH-1:0]                     mem_address,
  output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]     mem_wdata,
  output logic [CACHE_LINE_WIDTH/BURST_LEN/8-1:0]   mem_byte_enable,
  input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]     mem_rdata,
  input  logic                                      mem_resp,
  input  logic                                      pm_error
);

  localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int OFFS        = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int BCW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TOW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN       = (TIMEOUT_CYCLES != 0);

  localparam logic [BCW-1:0]        LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [TOW-1:0]        TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                      state_q;
  logic                        mem_read_q;
  logic                        mem_write_q;
  logic                        line_resp_q;
  logic                        busy_q;
  logic                        err_q;
  logic [ADDR_WIDTH-1:0]       mem_addr_q;
  logic [CACHE_LINE_WIDTH-1:0] line_rdata_q;
  logic [CACHE_LINE_WIDTH-1:0] rbuf_q;
  logic [CACHE_LINE_WIDTH-1:0] wbuf_q;
  logic [BCW-1:0]              beat_cnt_q;
  logic [TOW-1:0]              to_cnt_q;

  logic [CACHE_LINE_WIDTH-1:0] rd_line_d;
  logic [ADDR_WIDTH-1:0]       addr_aligned;
  logic                        in_burst;
  logic                        timeout_hit;
  logic                        req_conflict;
  logic                        fault_now;

  assign addr_aligned = line_address & ~OFFS_MASK;
  assign in_burst     = (state_q == S_READ) || (state_q == S_WRITE);

  // Merge the incoming beat into the partial line; only committed on the last beat
  // so line_rdata keeps the previous line stable for the whole of a new read.
  always_comb begin
    rd_line_d = rbuf_q;
    rd_line_d[beat_cnt_q*BURST_WIDTH +: BURST_WIDTH] = mem_rdata;
  end

  // Any condition that sends a live state to ERROR on this edge.
  always_comb begin
    timeout_hit  = TO_EN && in_burst && !mem_resp && (to_cnt_q == TO_LAST);
    req_conflict = (state_q == S_IDLE) && line_read && line_write;
    fault_now    = (state_q != S_ERROR) && (pm_error || timeout_hit || req_conflict);
  end

  // Write beat and strobes follow the beat counter directly so beat 0 is on the bus
  // from the first WRITE cycle; the bus is quiet in every other state.
  always_comb begin
    mem_wdata       = '0;
    mem_byte_enable = '0;
    if (state_q == S_WRITE) begin
      mem_wdata       = wbuf_q[beat_cnt_q*BURST_WIDTH +: BURST_WIDTH];
      mem_byte_enable = '1;
    end
  end

  // Main controller: state, beat/timeout counters, line buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      line_resp_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      line_rdata_q <= '0;
      rbuf_q       <= '0;
      wbuf_q       <= '0;
      beat_cnt_q   <= '0;
      to_cnt_q     <= '0;
    end else if (fault_now) begin
      // Sticky: only rst leaves ERROR, and no completion is reported.
      state_q     <= S_ERROR;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      line_resp_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b1;
    end else begin
      line_resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // mem_resp is deliberately ignored here.
          to_cnt_q   <= '0;
          beat_cnt_q <= '0;
          if (line_read) begin
            state_q    <= S_READ;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            mem_addr_q <= addr_aligned;
          end else if (line_write) begin
            state_q     <= S_WRITE;
            mem_write_q <= 1'b1;
            busy_q      <= 1'b1;
            mem_addr_q  <= addr_aligned;
            wbuf_q      <= line_wdata;
          end
        end

        S_READ: begin
          if (mem_resp) begin
            to_cnt_q   <= '0;
            rbuf_q     <= rd_line_d;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q      <= S_DONE;
              mem_read_q   <= 1'b0;
              line_resp_q  <= 1'b1;
              line_rdata_q <= rd_line_d;
            end
          end else begin
            // Gaps between beats are legal; only a gap reaching the limit is fatal.
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        S_WRITE: begin
          if (mem_resp) begin
            to_cnt_q   <= '0;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q     <= S_DONE;
              mem_write_q <= 1'b0;
              line_resp_q <= 1'b1;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          // Requests are not sampled here, forcing one IDLE cycle between bursts.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_ERROR;
        end
      endcase
    end
  end

  assign line_rdata  = line_rdata_q;
  assign line_resp   = line_resp_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_addr_q;

endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// Directed bench for cacheline_mem_adapter with an inline burst responder and a
// scoreboard queue of expected lines (read data / written-back memory lines).
module tb_cacheline_mem_adapter;
  localparam int LW = 256;
  localparam int BL = 4;
  localparam int BW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_read, line_write;
  logic [AW-1:0] line_address;
  logic [LW-1:0] line_wdata, line_rdata;
  logic          line_resp, busy, err;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_byte_enable;
  logic          mem_resp, pm_error;

  cacheline_mem_adapter #(
    .CACHE_LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write), .line_address(line_address),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .busy(busy), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pm_error(pm_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] mem_m [logic [AW-1:0]];
  logic [LW-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_read"}, LW'(mem_read), LW'(0));
    chk({tag, "_mem_write"}, LW'(mem_write), LW'(0));
    chk({tag, "_line_resp"}, LW'(line_resp), LW'(0));
  endtask

  // Issue a read, play the responder with delay d (optional gap before beat 2),
  // and compare the completed line against the scoreboard. Ends in the DONE cycle.
  task automatic run_read(input logic [AW-1:0] addr, input int d, input bit gap);
    logic [AW-1:0] base;
    logic [LW-1:0] src;
    logic [LW-1:0] exp;
    base = addr & ~32'h1F;
    src  = mem_m[base];
    line_address = addr;
    line_read = 1'b1;
    sb_q.push_back(src);
    step();
    line_read = 1'b0;
    chk("rd_start", LW'({mem_read, mem_write, busy}), LW'(3'b101));
    chk("rd_addr", LW'(mem_address), LW'(base));
    for (int i = 0; i < d; i++) begin
      step();
      chk("rd_wait_hold", LW'({mem_read, mem_address}), LW'({1'b1, base}));
    end
    for (int b = 0; b < BL; b++) begin
      if (gap && b == 2) begin
        mem_resp = 1'b0;
        step();
        chk("rd_gap_hold", LW'({mem_read, err}), LW'(2'b10));
      end
      mem_resp  = 1'b1;
      mem_rdata = src[b*BW +: BW];
      chk("rd_beat_mem_read", LW'({mem_read, line_resp}), LW'(2'b10));
      step();
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    chk("rd_resp", LW'({line_resp, mem_read, busy}), LW'(3'b101));
    exp = sb_q.pop_front();
    chk("rd_line", line_rdata, exp);
    chk("rd_no_err", LW'(err), LW'(0));
  endtask

  // Issue a write, capture beats as the responder would, then compare the
  // resulting memory line against the scoreboard. Ends in the DONE cycle.
  task automatic run_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int d);
    logic [AW-1:0] base;
    logic [LW-1:0] cap;
    logic [LW-1:0] exp;
    base = addr & ~32'h1F;
    cap  = '0;
    line_address = addr;
    line_wdata = line;
    line_write = 1'b1;
    sb_q.push_back(line);
    step();
    line_write = 1'b0;
    line_wdata = '0;
    chk("wr_start", LW'({mem_read, mem_write, busy}), LW'(3'b011));
    chk("wr_addr", LW'(mem_address), LW'(base));
    for (int i = 0; i < d; i++) begin
      chk("wr_beat0_early", LW'(mem_wdata), LW'(line[BW-1:0]));
      step();
    end
    for (int b = 0; b < BL; b++) begin
      mem_resp = 1'b1;
      chk("wr_wdata", LW'(mem_wdata), LW'(line[b*BW +: BW]));
      chk("wr_be", LW'({mem_write, mem_byte_enable}), LW'(9'h1FF));
      cap[b*BW +: BW] = mem_wdata;
      step();
    end
    mem_resp = 1'b0;
    mem_m[base] = cap;
    chk("wr_resp", LW'({line_resp, mem_write, busy}), LW'(3'b101));
    chk("wr_bus_idle", LW'({mem_wdata, mem_byte_enable}), LW'(0));
    exp = sb_q.pop_front();
    chk("wr_mem_line", mem_m[base], exp);
  endtask

  // DONE -> IDLE: completion pulse must be a single cycle.
  task automatic done_to_idle(input string tag);
    step();
    chk({tag, "_idle"}, LW'({line_resp, busy, err}), LW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] wl, wl2;

    rst = 1'b1;
    line_read = 1'b0;
    line_write = 1'b0;
    line_address = '0;
    line_wdata = '0;
    mem_rdata = '0;
    mem_resp = 1'b0;
    pm_error = 1'b0;
    mem_m[32'h40] = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                     64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};

    // Reset values
    step();
    step();
    chk_quiet("rst");
    chk("rst_flags", LW'({busy, err}), LW'(0));
    chk("rst_addr", LW'(mem_address), LW'(0));
    chk("rst_rdata", line_rdata, LW'(0));
    chk("rst_bus", LW'({mem_wdata, mem_byte_enable}), LW'(0));
    rst = 1'b0;

    // Stray mem_resp in IDLE does nothing
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("idle_resp_ignored", LW'({busy, mem_read, mem_write, line_resp}), LW'(0));

    // Read with D=5 from an unaligned address inside line 0x40
    run_read(32'h4C, 5, 1'b0);
    done_to_idle("rd1");
    chk("rd1_held", line_rdata, mem_m[32'h40]);

    // Write line 0x80, beat i = byte A0+i repeated
    for (int i = 0; i < BL; i++) wl[i*BW +: BW] = {8{8'(8'hA0 + i)}};
    run_write(32'h80, wl, 2);
    done_to_idle("wr1");

    // Read it back immediately-ish with D=0 and a mid-burst gap
    run_read(32'h9F, 0, 1'b1);
    done_to_idle("rd2");

    // Back-to-back: write then read the same line, request held through DONE
    wl2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_write(32'hC4, wl2, 1);
    line_read = 1'b1;
    line_address = 32'hC0;
    step();
    chk("b2b_idle_gap", LW'({busy, mem_read, mem_write}), LW'(0));
    run_read(32'hC0, 1, 1'b0);
    chk("b2b_data", line_rdata, wl2);
    done_to_idle("rd3");

    // Conflicting requests -> sticky ERROR with no bus activity
    line_read = 1'b1;
    line_write = 1'b1;
    line_address = 32'h100;
    step();
    line_read = 1'b0;
    line_write = 1'b0;
    chk("conf_err", LW'({err, busy}), LW'(2'b11));
    chk_quiet("conf");
    for (int i = 0; i < 3; i++) begin
      mem_resp = ~mem_resp;
      line_read = 1'b1;
      step();
      chk("conf_sticky", LW'({err, mem_read, mem_write, line_resp}), LW'(4'b1000));
    end
    mem_resp = 1'b0;
    line_read = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("conf_rst", LW'({err, busy}), LW'(0));

    // Timeout: responder silent, err after 8 READ cycles
    line_read = 1'b1;
    line_address = 32'h40;
    step();
    line_read = 1'b0;
    chk("to_start", LW'(mem_read), LW'(1));
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_not_yet", LW'({err, mem_read}), LW'(2'b01));
    end
    step();
    chk("to_err", LW'({err, busy, mem_read, line_resp}), LW'(4'b1100));
    rst = 1'b1;
    step();
    rst = 1'b0;

    // pm_error mid-burst
    line_read = 1'b1;
    step();
    line_read = 1'b0;
    mem_resp = 1'b1;
    mem_rdata = 64'h1234;
    step();
    mem_resp = 1'b0;
    pm_error = 1'b1;
    step();
    pm_error = 1'b0;
    chk("pm_err", LW'({err, busy, mem_read, line_resp}), LW'(4'b1100));
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset during beat 2 of a read
    line_read = 1'b1;
    line_address = 32'h44;
    step();
    line_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp = 1'b1;
      mem_rdata = 64'hDEAD_0000 + 64'(b);
      step();
    end
    mem_rdata = 64'hDEAD_0002;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    chk_quiet("midrst");
    chk("midrst_flags", LW'({busy, err, mem_address}), LW'(0));
    chk("midrst_rdata", line_rdata, LW'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_no_resp", LW'({line_resp, busy}), LW'(0));
    end
    run_read(32'h40, 2, 1'b0);
    done_to_idle("rd4");

    chk("sb_empty", LW'(sb_q.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
